// File: rtl/rv32_types_pkg.sv
// Shared types for the rv32 pipeline: decoded-instruction and execute-result
// buffers plus the operation enums carried between the decode and execute stages.
package rv32_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_LUI
    } alu_op_t;

    typedef enum logic [3:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
    } branch_op_t;

    typedef enum logic [2:0] {
        MUL_NONE, MUL_MUL, MUL_MULH, MUL_MULHSU, MUL_MULHU
    } mul_op_t;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        alu_op_t     alu_op;
        branch_op_t  branch_op;
        mul_op_t     mul_op;
        mem_op_t     mem_op;
    } decoded_buffer_data_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        reg_write;
        mem_op_t     mem_op;
    } exec_buffer_data_t;

    // Conditional branches never write a register; jumps write the link address.
    function automatic logic isConditional(input branch_op_t op);
        return (op == BR_BEQ) || (op == BR_BNE) || (op == BR_BLT) ||
               (op == BR_BGE) || (op == BR_BLTU) || (op == BR_BGEU);
    endfunction

endpackage

// File: rtl/rv32_int_alu.sv
// Single-cycle integer ALU. LUI returns op2 untouched, since the decoder
// already places the shifted upper immediate there.
module rv32_int_alu
    import rv32_types_pkg::*;
(
    input  alu_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    // Pure combinational operation select; shifts use only the low five bits of b.
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'b0, a_i < b_i};
            ALU_LUI:  result_o = b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv32_iter_multiplier.sv
// Iterative shift-add multiplier for RV32M. Operands are converted to
// magnitudes on start, multiplied one bit per cycle, and the sign is applied
// to the 64-bit product once the DONE state is reached.
module rv32_iter_multiplier
    import rv32_types_pkg::*;
#(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        hold_i,
    input  mul_op_t     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  rd_i,
    input  logic        regWrite_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [31:0] pc_o,
    output logic [4:0]  rd_o,
    output logic        regWrite_o
);

    localparam int CW = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   acc_q, mcand_q;
    logic [31:0]   mplier_q;
    logic          negate_q;
    mul_op_t       op_q;
    logic [31:0]   pc_q;
    logic [4:0]    rd_q;
    logic          regWrite_q;

    logic        aNeg, bNeg;
    logic [31:0] aMag, bMag;
    logic [63:0] product;

    // Operand signedness depends on the flavour: MULHU is fully unsigned,
    // MULHSU only treats the first operand as signed.
    always_comb begin
        aNeg = a_i[31] && (op_i == MUL_MUL || op_i == MUL_MULH || op_i == MUL_MULHSU);
        bNeg = b_i[31] && (op_i == MUL_MUL || op_i == MUL_MULH);
        aMag = aNeg ? (~a_i + 32'd1) : a_i;
        bMag = bNeg ? (~b_i + 32'd1) : b_i;
    end

    // IDLE -> BUSY on start, BUSY for MUL_CYCLES edges, DONE until the consumer can take it.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_BUSY;
                    count_d = '0;
                end
            end
            ST_BUSY: begin
                count_d = count_q + 1'b1;
                if (count_q == LAST_COUNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!hold_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and the shift-add datapath; a start captures the instruction context.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            negate_q   <= 1'b0;
            op_q       <= MUL_NONE;
            pc_q       <= '0;
            rd_q       <= '0;
            regWrite_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (state_q == ST_IDLE && start_i) begin
                acc_q      <= '0;
                mcand_q    <= {32'b0, aMag};
                mplier_q   <= bMag;
                negate_q   <= aNeg ^ bNeg;
                op_q       <= op_i;
                pc_q       <= pc_i;
                rd_q       <= rd_i;
                regWrite_q <= regWrite_i;
            end else if (state_q == ST_BUSY) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= {mcand_q[62:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[31:1]};
            end
        end
    end

    // Sign-correct the magnitude product and pick the requested half.
    always_comb begin
        product  = negate_q ? (~acc_q + 64'd1) : acc_q;
        result_o = (op_q == MUL_MUL) ? product[31:0] : product[63:32];
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign pc_o       = pc_q;
    assign rd_o       = rd_q;
    assign regWrite_o = regWrite_q;

endmodule

// File: rtl/rv32_execute_stage.sv
// Execute stage: single-cycle ALU ops, branch/jump resolution and iterative
// RV32M multiplies, feeding a registered result buffer to the memory stage.
module rv32_execute_stage
    import rv32_types_pkg::*;
#(
    parameter int          MUL_CYCLES      = 32,
    parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  decoded_buffer_data_t decode_data,
    input  logic                 mem_stall,
    output logic                 exec_stall,
    output exec_buffer_data_t    exec_data,
    output logic                 branch_taken,
    output logic [31:0]          branch_target
);

    exec_buffer_data_t execData_q, execData_d;
    logic              branchTaken_q, branchTaken_d;
    logic [31:0]       branchTarget_q, branchTarget_d;

    logic        mulBusy, mulDone, mulRegWrite;
    logic [31:0] mulResult, mulPc;
    logic [4:0]  mulRd;
    logic [31:0] aluResult;
    logic        accept, isMul, isBranch, mulStart;
    logic        condMet;
    logic [31:0] addrSum, pcPlus4, pcPlusImm, jumpTarget;

    // While a branch is in the output register, the input is wrong-path and is dropped.
    assign accept   = !mulBusy && !mem_stall && decode_data.valid && !branchTaken_q;
    assign isMul    = (decode_data.mul_op != MUL_NONE);
    assign isBranch = (decode_data.branch_op != BR_NONE);
    assign mulStart = accept && isMul;

    assign addrSum    = decode_data.op1 + decode_data.imm;
    assign pcPlus4    = decode_data.pc + 32'd4;
    assign pcPlusImm  = decode_data.pc + decode_data.imm;
    assign jumpTarget = (decode_data.branch_op == BR_JALR) ? {addrSum[31:1], 1'b0} : pcPlusImm;

    assign exec_stall = !reset && (mem_stall || mulBusy);

    rv32_int_alu u_alu (
        .op_i     (decode_data.alu_op),
        .a_i      (decode_data.op1),
        .b_i      (decode_data.op2),
        .result_o (aluResult)
    );

    rv32_iter_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk        (clk),
        .reset      (reset),
        .start_i    (mulStart),
        .hold_i     (mem_stall),
        .op_i       (decode_data.mul_op),
        .a_i        (decode_data.op1),
        .b_i        (decode_data.op2),
        .pc_i       (decode_data.pc),
        .rd_i       (decode_data.rd),
        .regWrite_i (decode_data.reg_write),
        .busy_o     (mulBusy),
        .done_o     (mulDone),
        .result_o   (mulResult),
        .pc_o       (mulPc),
        .rd_o       (mulRd),
        .regWrite_o (mulRegWrite)
    );

    // Branch condition: signed and unsigned compares of op1 against op2; jumps always go.
    always_comb begin
        condMet = 1'b0;
        case (decode_data.branch_op)
            BR_BEQ:  condMet = (decode_data.op1 == decode_data.op2);
            BR_BNE:  condMet = (decode_data.op1 != decode_data.op2);
            BR_BLT:  condMet = ($signed(decode_data.op1) <  $signed(decode_data.op2));
            BR_BGE:  condMet = ($signed(decode_data.op1) >= $signed(decode_data.op2));
            BR_BLTU: condMet = (decode_data.op1 <  decode_data.op2);
            BR_BGEU: condMet = (decode_data.op1 >= decode_data.op2);
            BR_JAL:  condMet = 1'b1;
            BR_JALR: condMet = 1'b1;
            default: condMet = 1'b0;
        endcase
    end

    // Next output register: hold on mem_stall, else a finished multiply, an accepted op, or a bubble.
    always_comb begin
        execData_d     = execData_q;
        branchTaken_d  = branchTaken_q;
        branchTarget_d = branchTarget_q;
        if (!mem_stall) begin
            execData_d    = '0;
            branchTaken_d = 1'b0;
            if (mulDone) begin
                execData_d.valid     = 1'b1;
                execData_d.pc        = mulPc;
                execData_d.result    = mulResult;
                execData_d.rd        = mulRd;
                execData_d.reg_write = mulRegWrite;
            end else if (accept && !isMul) begin
                execData_d.valid     = 1'b1;
                execData_d.pc        = decode_data.pc;
                execData_d.rs2_val   = decode_data.rs2_val;
                execData_d.rd        = decode_data.rd;
                execData_d.reg_write = decode_data.reg_write;
                execData_d.mem_op    = decode_data.mem_op;
                if (isBranch) begin
                    execData_d.result = pcPlus4;
                    if (isConditional(decode_data.branch_op)) begin
                        execData_d.reg_write = 1'b0;
                    end
                    branchTaken_d = condMet;
                    if (condMet) begin
                        branchTarget_d = jumpTarget;
                    end
                end else if (decode_data.mem_op != MEM_NONE) begin
                    execData_d.result = addrSum;
                end else begin
                    execData_d.result = aluResult;
                end
            end
        end
    end

    // Output register bank shared by result, redirect flag and redirect address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            execData_q     <= '0;
            branchTaken_q  <= 1'b0;
            branchTarget_q <= RESET_PC_TARGET;
        end else begin
            execData_q     <= execData_d;
            branchTaken_q  <= branchTaken_d;
            branchTarget_q <= branchTarget_d;
        end
    end

    assign exec_data     = execData_q;
    assign branch_taken  = branchTaken_q;
    assign branch_target = branchTarget_q;

endmodule

// File: tb/tb_rv32_execute_stage.sv
// Bench for rv32_execute_stage: directed cases with literal expectations,
// then randomized traffic checked cycle by cycle against a behavioural model.
module tb_rv32_execute_stage;
    import rv32_types_pkg::*;

    localparam logic [31:0] RST_TGT = 32'h0000_0800;

    logic                 clk = 1'b0;
    logic                 reset;
    decoded_buffer_data_t decode_data;
    logic                 mem_stall;
    logic                 exec_stall;
    exec_buffer_data_t    exec_data;
    logic                 branch_taken;
    logic [31:0]          branch_target;

    int total = 0;
    int bad   = 0;

    // Model state: what the registered outputs must hold, plus the multiply in flight.
    exec_buffer_data_t mData;
    logic              mTaken;
    logic [31:0]       mTarget;
    int                mLeft;
    exec_buffer_data_t mMulOut;
    logic              lastStall;

    always #5 clk = ~clk;

    rv32_execute_stage #(
        .MUL_CYCLES      (32),
        .RESET_PC_TARGET (RST_TGT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .decode_data   (decode_data),
        .mem_stall     (mem_stall),
        .exec_stall    (exec_stall),
        .exec_data     (exec_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    task automatic checkVal(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mData   = '0;
        mTaken  = 1'b0;
        mTarget = RST_TGT;
        mLeft   = 0;
        mMulOut = '0;
    endtask

    function automatic logic [31:0] refMul(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'b0, a};
        zb = {32'b0, b};
        case (op)
            MUL_MUL:    begin p = sa * sb; return p[31:0];  end
            MUL_MULH:   begin p = sa * sb; return p[63:32]; end
            MUL_MULHSU: begin p = sa * zb; return p[63:32]; end
            default:    begin p = za * zb; return p[63:32]; end
        endcase
    endfunction

    task automatic refExec(input decoded_buffer_data_t d, output exec_buffer_data_t o,
                           output logic tk, output logic [31:0] tg);
        logic [31:0] a, b;
        a = d.op1;
        b = d.op2;
        o = '0;
        o.valid = 1'b1;
        o.pc = d.pc;
        o.rs2_val = d.rs2_val;
        o.rd = d.rd;
        o.reg_write = d.reg_write;
        o.mem_op = d.mem_op;
        tk = 1'b0;
        tg = d.pc + d.imm;
        if (d.branch_op != BR_NONE) begin
            o.result = d.pc + 32'd4;
            case (d.branch_op)
                BR_BEQ:  tk = (a == b);
                BR_BNE:  tk = (a != b);
                BR_BLT:  tk = ($signed(a) < $signed(b));
                BR_BGE:  tk = !($signed(a) < $signed(b));
                BR_BLTU: tk = (a < b);
                BR_BGEU: tk = !(a < b);
                default: tk = 1'b1;
            endcase
            if (d.branch_op != BR_JAL && d.branch_op != BR_JALR) o.reg_write = 1'b0;
            if (d.branch_op == BR_JALR) tg = (a + d.imm) & 32'hFFFF_FFFE;
        end else if (d.mem_op != MEM_NONE) begin
            o.result = a + d.imm;
        end else begin
            case (d.alu_op)
                ALU_ADD:  o.result = a + b;
                ALU_SUB:  o.result = a - b;
                ALU_AND:  o.result = a & b;
                ALU_OR:   o.result = a | b;
                ALU_XOR:  o.result = a ^ b;
                ALU_SLL:  o.result = a << b[4:0];
                ALU_SRL:  o.result = a >> b[4:0];
                ALU_SRA:  o.result = $unsigned($signed(a) >>> b[4:0]);
                ALU_SLT:  o.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                ALU_SLTU: o.result = (a < b) ? 32'd1 : 32'd0;
                default:  o.result = b;
            endcase
        end
    endtask

    // One clock edge of the stage as seen from outside.
    task automatic modelAdvance(input decoded_buffer_data_t d, input logic ms);
        exec_buffer_data_t o;
        logic tk;
        logic [31:0] tg;
        if (mLeft > 1) begin
            mLeft--;
            if (!ms) begin
                mData  = '0;
                mTaken = 1'b0;
            end
        end else if (mLeft == 1) begin
            if (!ms) begin
                mData  = mMulOut;
                mTaken = 1'b0;
                mLeft  = 0;
            end
        end else if (!ms) begin
            if (d.valid && !mTaken) begin
                if (d.mul_op != MUL_NONE) begin
                    mMulOut = '0;
                    mMulOut.valid = 1'b1;
                    mMulOut.pc = d.pc;
                    mMulOut.rd = d.rd;
                    mMulOut.reg_write = d.reg_write;
                    mMulOut.result = refMul(d.mul_op, d.op1, d.op2);
                    mLeft  = 33;
                    mData  = '0;
                    mTaken = 1'b0;
                end else begin
                    refExec(d, o, tk, tg);
                    mData  = o;
                    mTaken = tk;
                    if (tk) mTarget = tg;
                end
            end else begin
                mData  = '0;
                mTaken = 1'b0;
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("exec_data", 128'(exec_data), 128'(mData));
        checkVal("branch_taken", 128'(branch_taken), 128'(mTaken));
        checkVal("branch_target", 128'(branch_target), 128'(mTarget));
    endtask

    // Drive one cycle of input, check the stall, step the model, then check registered outputs.
    task automatic applyStimulus(input decoded_buffer_data_t d, input logic ms);
        @(negedge clk);
        decode_data = d;
        mem_stall   = ms;
        #1;
        lastStall = exec_stall;
        checkVal("exec_stall", 128'(exec_stall), 128'(ms || (mLeft > 0)));
        modelAdvance(d, ms);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    function automatic decoded_buffer_data_t bubble();
        decoded_buffer_data_t d;
        d = '0;
        return d;
    endfunction

    function automatic decoded_buffer_data_t mkAlu(input alu_op_t op, input logic [31:0] a,
                                                   input logic [31:0] b, input logic [4:0] rd);
        decoded_buffer_data_t d;
        d = '0;
        d.valid = 1'b1;
        d.pc = 32'h0000_0010;
        d.op1 = a;
        d.op2 = b;
        d.rd = rd;
        d.reg_write = 1'b1;
        d.alu_op = op;
        return d;
    endfunction

    function automatic decoded_buffer_data_t mkMul(input mul_op_t op, input logic [31:0] a, input logic [31:0] b);
        decoded_buffer_data_t d;
        d = mkAlu(ALU_ADD, a, b, 5'd9);
        d.pc = 32'h0000_0200;
        d.mul_op = op;
        return d;
    endfunction

    function automatic decoded_buffer_data_t randInstr();
        decoded_buffer_data_t d;
        int r;
        d = '0;
        d.valid = ($urandom_range(0, 9) != 0);
        d.pc = $urandom & 32'hFFFF_FFFC;
        d.op1 = $urandom;
        d.op2 = ($urandom_range(0, 3) == 0) ? d.op1 : $urandom;
        d.rs2_val = $urandom;
        d.imm = $urandom;
        d.rd = 5'($urandom);
        d.reg_write = 1'($urandom);
        d.alu_op = alu_op_t'(4'($urandom_range(0, 10)));
        r = $urandom_range(0, 99);
        if (r < 8)       d.mul_op = mul_op_t'(3'($urandom_range(1, 4)));
        else if (r < 30) d.branch_op = branch_op_t'(4'($urandom_range(1, 8)));
        else if (r < 45) d.mem_op = mem_op_t'(4'($urandom_range(1, 8)));
        return d;
    endfunction

    // Run one multiply to completion and pin its latency and result.
    task automatic runMul(input string name, input mul_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected);
        int n;
        int stallCnt;
        applyStimulus(mkMul(op, a, b), 1'b0);
        n = 0;
        stallCnt = 0;
        while (!exec_data.valid && n < 40) begin
            applyStimulus(bubble(), 1'b0);
            n++;
            if (lastStall) stallCnt++;
        end
        checkVal({name, "_latency"}, 128'(n), 128'(33));
        checkVal({name, "_stall_cycles"}, 128'(stallCnt), 128'(33));
        checkVal({name, "_result"}, 128'(exec_data.result), 128'(expected));
        checkVal({name, "_model"}, 128'(mData.result), 128'(expected));
    endtask

    initial begin
        decoded_buffer_data_t d;

        reset = 1'b1;
        mem_stall = 1'b1;
        decode_data = '0;
        modelReset();
        #3;
        checkVal("reset_exec_stall", 128'(exec_stall), 128'(0));
        checkVal("reset_exec_data", 128'(exec_data), 128'(0));
        checkVal("reset_taken", 128'(branch_taken), 128'(0));
        checkVal("reset_target", 128'(branch_target), 128'(RST_TGT));
        @(negedge clk);
        reset = 1'b0;
        mem_stall = 1'b0;

        applyStimulus(mkAlu(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 5'd5), 1'b0);
        checkVal("add_valid", 128'(exec_data.valid), 128'(1));
        checkVal("add_result", 128'(exec_data.result), 128'(0));
        checkVal("add_rd", 128'(exec_data.rd), 128'(5));

        applyStimulus(mkAlu(ALU_SRA, 32'h8000_0000, 32'h24, 5'd6), 1'b0);
        checkVal("sra_result", 128'(exec_data.result), 128'(32'hF800_0000));
        applyStimulus(mkAlu(ALU_SLTU, 32'h1, 32'hFFFF_FFFF, 5'd7), 1'b0);
        checkVal("sltu_result", 128'(exec_data.result), 128'(1));

        d = mkAlu(ALU_ADD, 32'd7, 32'd7, 5'd3);
        d.branch_op = BR_BEQ;
        d.pc = 32'h100;
        d.imm = 32'h20;
        applyStimulus(d, 1'b0);
        checkVal("beq_taken", 128'(branch_taken), 128'(1));
        checkVal("beq_target", 128'(branch_target), 128'(32'h120));
        checkVal("beq_reg_write", 128'(exec_data.reg_write), 128'(0));
        applyStimulus(mkAlu(ALU_ADD, 32'd1, 32'd2, 5'd4), 1'b0);
        checkVal("squash_valid", 128'(exec_data.valid), 128'(0));
        checkVal("squash_taken", 128'(branch_taken), 128'(0));

        d = mkAlu(ALU_ADD, 32'h203, 32'h0, 5'd1);
        d.branch_op = BR_JALR;
        d.pc = 32'h40;
        d.imm = 32'h1;
        applyStimulus(d, 1'b0);
        checkVal("jalr_target", 128'(branch_target), 128'(32'h204));
        checkVal("jalr_result", 128'(exec_data.result), 128'(32'h44));
        checkVal("jalr_reg_write", 128'(exec_data.reg_write), 128'(1));
        applyStimulus(bubble(), 1'b0);

        runMul("mulhu", MUL_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runMul("mulh", MUL_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        runMul("mul", MUL_MUL, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        runMul("mulhsu", MUL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Multiply parked in DONE behind a stalled memory stage.
        applyStimulus(mkMul(MUL_MUL, 32'd3, 32'd5), 1'b0);
        repeat (32) applyStimulus(bubble(), 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bubble(), 1'b1);
            checkVal("done_hold_valid", 128'(exec_data.valid), 128'(0));
            checkVal("done_hold_stall", 128'(lastStall), 128'(1));
        end
        applyStimulus(bubble(), 1'b0);
        checkVal("done_release_valid", 128'(exec_data.valid), 128'(1));
        checkVal("done_release_result", 128'(exec_data.result), 128'(15));
        applyStimulus(bubble(), 1'b0);
        checkVal("done_one_cycle", 128'(exec_data.valid), 128'(0));

        // Reset in the middle of an iteration.
        applyStimulus(mkMul(MUL_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 1'b0);
        repeat (10) applyStimulus(bubble(), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("midmul_reset_valid", 128'(exec_data.valid), 128'(0));
        checkVal("midmul_reset_stall", 128'(exec_stall), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("after_reset_idle", 128'(exec_stall), 128'(0));
        applyStimulus(mkAlu(ALU_ADD, 32'd40, 32'd2, 5'd8), 1'b0);
        checkVal("after_reset_add", 128'(exec_data.result), 128'(42));
        checkVal("after_reset_add_valid", 128'(exec_data.valid), 128'(1));

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(randInstr(), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
